// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared widths, state encoding and helpers for the cache-line to memory-burst adaptor.
package cacheline_adaptor_pkg;

   localparam int unsigned W_LINE   = 256;
   localparam int unsigned W_BURST  = 64;
   localparam int unsigned BEATS    = W_LINE / W_BURST;
   localparam int unsigned S_OFFSET = 5;
   localparam int unsigned W_ADDR   = 32;
   localparam int unsigned W_CNT    = $clog2(BEATS);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

   typedef logic [W_CNT-1:0]   beat_cnt_t;
   typedef logic [W_BURST-1:0] beat_t;

   // Clear the line-offset bits so the burst always starts on a line boundary.
   function automatic logic [W_ADDR-1:0] line_align(input logic [W_ADDR-1:0] addr);
      return {addr[W_ADDR-1:S_OFFSET], S_OFFSET'(0)};
   endfunction

endpackage

// File: rtl/cacheline_burst_adaptor_if.sv
// Cache-side and memory-side bundles of the line/burst adaptor.
interface cacheline_line_if;
   import cacheline_adaptor_pkg::*;

   logic [W_ADDR-1:0] line_address;
   logic              line_read;
   logic              line_write;
   logic [W_LINE-1:0] line_wdata;
   logic [W_LINE-1:0] line_rdata;
   logic              line_resp;

   modport master (output line_address, line_read, line_write, line_wdata,
                   input  line_rdata, line_resp);
   modport slave  (input  line_address, line_read, line_write, line_wdata,
                   output line_rdata, line_resp);
endinterface

interface cacheline_burst_if;
   import cacheline_adaptor_pkg::*;

   logic [W_ADDR-1:0]  burst_address;
   logic               burst_read;
   logic               burst_write;
   logic [W_BURST-1:0] burst_wdata;
   logic [W_BURST-1:0] burst_rdata;
   logic               burst_resp;

   modport master (output burst_address, burst_read, burst_write, burst_wdata,
                   input  burst_rdata, burst_resp);
   modport slave  (input  burst_address, burst_read, burst_write, burst_wdata,
                   output burst_rdata, burst_resp);
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Splits one cache-line read/write into a burst of memory beats and reassembles reads.
module cacheline_burst_adaptor
   import cacheline_adaptor_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   cacheline_line_if.slave   line,
   cacheline_burst_if.master burst
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_RD   = RD;
   localparam logic [1:0] ST_WR   = WR;
   localparam logic [1:0] ST_DONE = DONE;

   logic [1:0]                    state_q, state_d;
   beat_cnt_t                     cnt_q, cnt_d;
   logic [BEATS-1:0][W_BURST-1:0] rbuf_q, rbuf_d;
   logic [BEATS-1:0][W_BURST-1:0] wbuf_q, wbuf_d;
   logic [W_ADDR-1:0]             addr_q, addr_d;
   logic                          rd_q, rd_d;
   logic                          wr_q, wr_d;
   logic                          resp_q, resp_d;
   beat_t                         wdata_q, wdata_d;

   logic last_beat_c;
   assign last_beat_c = (cnt_q == W_CNT'(BEATS - 1));

   // Next-state and next-output logic; outputs are registered from the *_d values.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rbuf_d  = rbuf_q;
      wbuf_d  = wbuf_q;
      addr_d  = addr_q;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      resp_d  = 1'b0;
      wdata_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (line.line_read) begin
               addr_d  = line_align(line.line_address);
               rd_d    = 1'b1;
               state_d = ST_RD;
            end else if (line.line_write) begin
               addr_d  = line_align(line.line_address);
               wbuf_d  = line.line_wdata;
               wr_d    = 1'b1;
               wdata_d = line.line_wdata[W_BURST-1:0];
               state_d = ST_WR;
            end
         end
         ST_RD: begin
            rd_d = 1'b1;
            if (burst.burst_resp) begin
               rbuf_d[cnt_q] = burst.burst_rdata;
               if (last_beat_c) begin
                  cnt_d   = '0;
                  rd_d    = 1'b0;
                  resp_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  cnt_d = beat_cnt_t'(cnt_q + 1'b1);
               end
            end
         end
         ST_WR: begin
            wr_d    = 1'b1;
            wdata_d = wbuf_q[cnt_q];
            if (burst.burst_resp) begin
               if (last_beat_c) begin
                  cnt_d   = '0;
                  wr_d    = 1'b0;
                  wdata_d = '0;
                  resp_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  cnt_d   = beat_cnt_t'(cnt_q + 1'b1);
                  wdata_d = wbuf_q[beat_cnt_t'(cnt_q + 1'b1)];
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rbuf_q  <= '0;
         wbuf_q  <= '0;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         resp_q  <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rbuf_q  <= rbuf_d;
         wbuf_q  <= wbuf_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         resp_q  <= resp_d;
         wdata_q <= wdata_d;
      end
   end

   assign line.line_rdata     = rbuf_q;
   assign line.line_resp      = resp_q;
   assign burst.burst_address = addr_q;
   assign burst.burst_read    = rd_q;
   assign burst.burst_write   = wr_q;
   assign burst.burst_wdata   = wdata_q;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed plus randomized bench for cacheline_burst_adaptor against a line-level memory model.
module tb_cacheline_burst_adaptor;

   logic clk = 1'b0;
   logic rst;

   cacheline_line_if  line_bus ();
   cacheline_burst_if burst_bus ();

   cacheline_burst_adaptor dut (
      .clk   (clk),
      .rst   (rst),
      .line  (line_bus),
      .burst (burst_bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [255:0] exp_rdata;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_rd"},   {255'd0, burst_bus.burst_read},  256'd0);
      check({tag, "_wr"},   {255'd0, burst_bus.burst_write}, 256'd0);
      check({tag, "_resp"}, {255'd0, line_bus.line_resp},    256'd0);
   endtask

   // Read one line; the memory returns `data` beat by beat. pat_len>0 fixes the resp pattern,
   // abort_after>=0 pulses rst once that many beats have been accepted.
   task automatic do_read(input logic [31:0] addr, input logic [255:0] data, input logic both,
                          input logic [15:0] pat, input int pat_len, input int abort_after);
      int beat = 0;
      int cyc  = 0;
      logic r;
      logic [31:0] exp_addr;
      exp_addr = addr & ~32'h1f;
      @(negedge clk);
      line_bus.line_read    = 1'b1;
      line_bus.line_write   = both;
      line_bus.line_address = addr;
      line_bus.line_wdata   = rand_line();
      while (beat < 4) begin
         @(negedge clk);
         if (abort_after >= 0 && beat == abort_after) begin
            rst = 1'b1;
            burst_bus.burst_resp = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            line_bus.line_read  = 1'b0;
            line_bus.line_write = 1'b0;
            exp_rdata = '0;
            check_quiet("abort");
            check("abort_addr", {224'd0, burst_bus.burst_address}, 256'd0);
            check("abort_wdata", {192'd0, burst_bus.burst_wdata}, 256'd0);
            check("abort_rdata", line_bus.line_rdata, exp_rdata);
            @(negedge clk);
            check_quiet("abort_after");
            return;
         end
         check("rd_req",  {255'd0, burst_bus.burst_read},  256'd1);
         check("rd_nowr", {255'd0, burst_bus.burst_write}, 256'd0);
         check("rd_addr", {224'd0, burst_bus.burst_address}, {224'd0, exp_addr});
         check("rd_noresp", {255'd0, line_bus.line_resp}, 256'd0);
         if (beat == 0 && cyc == 0) check("rd_hold_old", line_bus.line_rdata, exp_rdata);
         if (pat_len > 0) r = (cyc < pat_len) ? pat[cyc] : 1'b1;
         else             r = (cyc > 12) ? 1'b1 : 1'($urandom_range(0, 1));
         burst_bus.burst_resp  = r;
         burst_bus.burst_rdata = r ? data[beat*64 +: 64] : {$urandom, $urandom};
         if (r) beat++;
         line_bus.line_address = $urandom;
         line_bus.line_wdata   = rand_line();
         cyc++;
      end
      @(negedge clk);
      burst_bus.burst_resp = 1'b0;
      exp_rdata = data;
      check("rd_done_resp", {255'd0, line_bus.line_resp}, 256'd1);
      check("rd_done_rd",   {255'd0, burst_bus.burst_read}, 256'd0);
      check("rd_done_wr",   {255'd0, burst_bus.burst_write}, 256'd0);
      check("rd_line",      line_bus.line_rdata, exp_rdata);
      line_bus.line_read  = 1'b0;
      line_bus.line_write = 1'b0;
      @(negedge clk);
      check_quiet("rd_post");
      check("rd_line_hold", line_bus.line_rdata, exp_rdata);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [255:0] data);
      int beat = 0;
      int cyc  = 0;
      logic r;
      logic [31:0] exp_addr;
      exp_addr = addr & ~32'h1f;
      @(negedge clk);
      line_bus.line_write   = 1'b1;
      line_bus.line_read    = 1'b0;
      line_bus.line_address = addr;
      line_bus.line_wdata   = data;
      while (beat < 4) begin
         @(negedge clk);
         check("wr_req",   {255'd0, burst_bus.burst_write}, 256'd1);
         check("wr_nord",  {255'd0, burst_bus.burst_read},  256'd0);
         check("wr_addr",  {224'd0, burst_bus.burst_address}, {224'd0, exp_addr});
         check("wr_beat",  {192'd0, burst_bus.burst_wdata}, {192'd0, data[beat*64 +: 64]});
         check("wr_noresp", {255'd0, line_bus.line_resp}, 256'd0);
         check("wr_rdata_kept", line_bus.line_rdata, exp_rdata);
         r = (cyc > 12) ? 1'b1 : 1'($urandom_range(0, 1));
         burst_bus.burst_resp  = r;
         burst_bus.burst_rdata = {$urandom, $urandom};
         if (r) beat++;
         line_bus.line_address = $urandom;
         line_bus.line_wdata   = rand_line();
         cyc++;
      end
      @(negedge clk);
      burst_bus.burst_resp = 1'b0;
      check("wr_done_resp", {255'd0, line_bus.line_resp}, 256'd1);
      check("wr_done_wr",   {255'd0, burst_bus.burst_write}, 256'd0);
      check("wr_done_rd",   {255'd0, burst_bus.burst_read}, 256'd0);
      check("wr_rdata_done", line_bus.line_rdata, exp_rdata);
      line_bus.line_write = 1'b0;
      @(negedge clk);
      check_quiet("wr_post");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [255:0] d;
      rst = 1'b1;
      exp_rdata = '0;
      line_bus.line_read    = 1'b0;
      line_bus.line_write   = 1'b0;
      line_bus.line_address = '0;
      line_bus.line_wdata   = '0;
      burst_bus.burst_rdata = '0;
      burst_bus.burst_resp  = 1'b0;
      repeat (2) @(negedge clk);
      check_quiet("reset");
      check("reset_addr",  {224'd0, burst_bus.burst_address}, 256'd0);
      check("reset_wdata", {192'd0, burst_bus.burst_wdata}, 256'd0);
      check("reset_rdata", line_bus.line_rdata, 256'd0);
      rst = 1'b0;

      // Ungapped read
      d = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
      do_read(32'h0000_1234, d, 1'b0, 16'h000f, 4, -1);

      // Write with beats AAAA.., BBBB.., CCCC.., DDDD..
      d = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
      do_write(32'h8000_00E0, d);

      // Gapped read: resp 1,0,0,1,0,1,1
      do_read(32'h0000_5678, rand_line(), 1'b0, 16'h0069, 7, -1);

      // Read and write together: read wins
      do_read(32'h1234_5600, rand_line(), 1'b1, 16'h0000, 0, -1);

      // Stray responses while idle
      repeat (3) begin
         @(negedge clk);
         burst_bus.burst_resp  = 1'b1;
         burst_bus.burst_rdata = {$urandom, $urandom};
         check("idle_rdata", line_bus.line_rdata, exp_rdata);
         check_quiet("idle");
      end
      @(negedge clk);
      burst_bus.burst_resp = 1'b0;
      check("idle_rdata_end", line_bus.line_rdata, exp_rdata);

      // Reset after two beats, then a fresh read
      do_read(32'h0000_4000, rand_line(), 1'b0, 16'h000f, 4, 2);
      do_read(32'h0000_4020, rand_line(), 1'b0, 16'h0000, 0, -1);

      // Back-to-back write then read, then random mix
      do_write(32'hCAFE_0040, rand_line());
      do_read(32'hCAFE_0040, rand_line(), 1'b0, 16'h0000, 0, -1);
      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(0, 1) == 0) do_write($urandom, rand_line());
         else                           do_read($urandom, rand_line(), 1'($urandom_range(0, 1)), 16'h0000, 0, -1);
      end

      repeat (2) @(negedge clk);
      check_quiet("final");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
